// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - display-side bus of the 7-segment scan driver.
// Optional bright field exists only when SCAN_BRIGHTNESS_EN is defined.
interface seg7_scan_driver_if;
  logic        en;
  logic [27:0] segs;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_done;
`ifdef SCAN_BRIGHTNESS_EN
  logic [3:0]  bright;

  modport master (output en, segs, bright, input seg_n, an_n, frame_done);
  modport slave  (input en, segs, bright, output seg_n, an_n, frame_done);
`else
  modport master (output en, segs, input seg_n, an_n, frame_done);
  modport slave  (input en, segs, output seg_n, an_n, frame_done);
`endif
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexes a 4-digit segment bus onto shared pins with blanking.
// SCAN_BRIGHTNESS_EN adds a per-frame brightness duty cycle within each lit phase.
module seg7_scan_driver #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                clk,
  input  logic                reset,
  seg7_scan_driver_if.slave   bus
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [27:0]   snap_q, snap_d;
  logic [3:0]    an_n_q, an_n_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic          frame_done_q, frame_done_d;
  logic          lit;
  logic [6:0]    seg_sel;
`ifdef SCAN_BRIGHTNESS_EN
  logic [3:0]    bright_q, bright_d;
  logic [31:0]   lit_len;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dig_d        = dig_q;
    snap_d       = snap_q;
    frame_done_d = 1'b0;
`ifdef SCAN_BRIGHTNESS_EN
    bright_d     = bright_q;
`endif
    // en low wins over every transition, including the frame_done of a just-finished frame
    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = '0;
      dig_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          dig_d   = '0;
          snap_d  = bus.segs;
`ifdef SCAN_BRIGHTNESS_EN
          bright_d = bus.bright;
`endif
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ON: begin
          if (cnt_q == DIGIT_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (dig_q == 2'd3) begin
              dig_d        = '0;
              frame_done_d = 1'b1;
              snap_d       = bus.segs;
`ifdef SCAN_BRIGHTNESS_EN
              bright_d     = bus.bright;
`endif
            end else begin
              dig_d = dig_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Pins are derived from the next state so they are registered without adding latency
`ifdef SCAN_BRIGHTNESS_EN
    lit_len = ((32'(bright_d) + 32'd1) * 32'(DIGIT_CYCLES)) >> 4;
    lit     = (state_d == ON) && (32'(cnt_d) < lit_len);
`else
    lit     = (state_d == ON);
`endif

    case (dig_d)
      2'd0:    seg_sel = snap_d[6:0];
      2'd1:    seg_sel = snap_d[13:7];
      2'd2:    seg_sel = snap_d[20:14];
      default: seg_sel = snap_d[27:21];
    endcase

    an_n_d  = lit ? ~(4'b0001 << dig_d) : 4'hF;
    seg_n_d = lit ? seg_sel : 7'h7F;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dig_q        <= '0;
      snap_q       <= 28'hFFFFFFF;
      an_n_q       <= 4'hF;
      seg_n_q      <= 7'h7F;
      frame_done_q <= 1'b0;
`ifdef SCAN_BRIGHTNESS_EN
      bright_q     <= 4'hF;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      snap_q       <= snap_d;
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
      frame_done_q <= frame_done_d;
`ifdef SCAN_BRIGHTNESS_EN
      bright_q     <= bright_d;
`endif
    end
  end

  assign bus.an_n       = an_n_q;
  assign bus.seg_n      = seg_n_q;
  assign bus.frame_done = frame_done_q;

endmodule
